// File: rtl/dma_pkg.sv
// Shared types and default widths for the single-channel word-copy DMA engine.
// Holds the FSM state encoding so the bench and any wrapper agree on it.
package dma_pkg;

    localparam int DMA_DATA_WIDTH = 32;
    localparam int DMA_ADDR_WIDTH = 32;
    localparam int DMA_LEN_WIDTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_DONE
    } dma_state_e;

endpackage

// File: rtl/dma_engine.sv
// Word-by-word memory copy: read one word, write it, repeat; 3 cycles/word minimum plus one DONE cycle.
// Requests hold address/data until mem_gnt; RD_WAIT stalls until mem_rvalid; abort returns to IDLE at once.
module dma_engine
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = DMA_DATA_WIDTH,
    parameter int ADDR_WIDTH = DMA_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DMA_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  xfer_count,
    output logic                  mem_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    dma_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]  xfer_count_q, xfer_count_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;

    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        remaining_d  = remaining_q;
        xfer_count_d = xfer_count_q;
        buf_d        = buf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    xfer_count_d = '0;
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        src_ptr_d   = src_addr;
                        dst_ptr_d   = dst_addr;
                        remaining_d = len;
                        state_d     = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (mem_gnt) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (mem_rvalid) begin
                    buf_d   = mem_rdata;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (mem_gnt) begin
                    // Pointers wrap silently at the top of the address space.
                    xfer_count_d = xfer_count_q + LEN_WIDTH'(1);
                    remaining_d  = remaining_q - LEN_WIDTH'(1);
                    src_ptr_d    = src_ptr_q + ADDR_WIDTH'(1);
                    dst_ptr_d    = dst_ptr_q + ADDR_WIDTH'(1);
                    state_d      = (remaining_q == LEN_WIDTH'(1)) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remaining_q  <= '0;
            xfer_count_q <= '0;
            buf_q        <= '0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            remaining_q  <= remaining_d;
            xfer_count_q <= xfer_count_d;
            buf_q        <= buf_d;
        end
    end

    // Every output is a decode of registered state, so mem_gnt never reaches mem_en combinationally.
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign mem_en     = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    assign mem_wr_en  = (state_q == ST_WR_REQ);
    assign mem_addr   = (state_q == ST_WR_REQ) ? dst_ptr_q : src_ptr_q;
    assign mem_wdata  = buf_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_dma_engine.sv
// Bench for dma_engine: table of copies, hand-written corner sequences, then random copies
// scored against an address-arithmetic model of what a copy must read and write.
module tb_dma_engine;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len;
    logic        busy, done;
    logic [15:0] xfer_count;
    logic        mem_en, mem_wr_en;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    dma_engine dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .xfer_count (xfer_count),
        .mem_en     (mem_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] n;
        int          pct;
        int          rvd;
        logic [15:0] exp_cnt;
        int          lat;     // cycles from start to done observed, -1 when grant timing is random
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          gnt_pct = 100;
    int          rv_delay = 0;
    bit          gnt_force = 1'b0;
    bit          gnt_val = 1'b1;
    bit          rd_pending = 1'b0;
    int          rd_cnt = 0;
    logic [31:0] rd_data;
    logic [31:0] rd_q[$];
    wr_t         wr_q[$];
    int          en_cycles = 0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // Called at a negedge: plays the memory controller for the coming posedge, then advances one cycle.
    task automatic run_cycle();
        mem_gnt    = gnt_force ? gnt_val : ($urandom_range(0, 99) < gnt_pct);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (rd_pending) begin
            if (rd_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_data;
                rd_pending = 1'b0;
            end else begin
                rd_cnt--;
            end
        end
        if (mem_en) en_cycles++;
        if (!rst && !abort && mem_en && mem_gnt) begin
            if (mem_wr_en) begin
                wr_q.push_back({mem_addr, mem_wdata});
            end else begin
                rd_q.push_back(mem_addr);
                rd_pending = 1'b1;
                rd_cnt     = rv_delay;
                rd_data    = memval(mem_addr);
            end
        end
        if (rst || abort) rd_pending = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic do_copy(input vec_t v, input string tag, input bit stray);
        int          lat = 0;
        bit          seen = 1'b0;
        logic [31:0] ea;
        int          nr, nw;
        rd_q.delete();
        wr_q.delete();
        en_cycles = 0;
        gnt_force = 1'b0;
        gnt_pct   = v.pct;
        rv_delay  = v.rvd;
        src_addr  = v.src;
        dst_addr  = v.dst;
        len       = v.n;
        start     = 1'b1;
        while (!seen && lat < 400) begin
            if (stray && lat > 0 && busy && $urandom_range(0, 7) == 0) begin
                start    = 1'b1;
                len      = 16'($urandom_range(1, 9));
                src_addr = $urandom;
            end
            run_cycle();
            lat++;
            seen = done;
        end
        check({tag, "_done_seen"}, seen, 1);
        if (v.lat >= 0) check({tag, "_latency"}, lat, v.lat);
        check({tag, "_busy_in_done"}, busy, 1);
        check({tag, "_xfer_count"}, xfer_count, v.exp_cnt);
        run_cycle();
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_idle_after"}, busy, 0);
        check({tag, "_count_held"}, xfer_count, v.exp_cnt);
        nr = rd_q.size();
        nw = wr_q.size();
        check({tag, "_num_reads"}, nr, v.n);
        check({tag, "_num_writes"}, nw, v.n);
        for (int i = 0; i < int'(v.n); i++) begin
            ea = v.src + 32'(i);
            if (i < nr) check({tag, "_rd_addr"}, rd_q[i], ea);
            if (i < nw) begin
                check({tag, "_wr_data"}, wr_q[i].d, memval(ea));
                ea = v.dst + 32'(i);
                check({tag, "_wr_addr"}, wr_q[i].a, ea);
            end
        end
        if (v.n == 0) check({tag, "_no_mem_en"}, en_cycles, 0);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t r;
        int   cyc;
        int   dcount;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
        mem_gnt = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;

        // Full-speed timing: 3 cycles per word (request, wait, write) plus the start cycle.
        tbl[0] = '{32'h0000_0100, 32'h0000_0200, 16'd3, 100, 0, 16'd3, 10};
        tbl[1] = '{32'h0000_0000, 32'h0000_0000, 16'd0, 100, 0, 16'd0, 1};
        tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0500, 16'd2, 100, 0, 16'd2, 7};
        tbl[3] = '{32'h0000_0040, 32'hFFFF_FFFE, 16'd3, 100, 2, 16'd3, 16};
        tbl[4] = '{32'h0000_1234, 32'h0000_8000, 16'd5, 40,  1, 16'd5, -1};
        tbl[5] = '{32'h0000_0010, 32'h0000_0020, 16'd1, 100, 3, 16'd1, 7};

        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        run_cycle();
        run_cycle();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_xfer_count", xfer_count, 0);
        check("reset_mem_en", mem_en, 0);
        check("reset_mem_wr_en", mem_wr_en, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        run_cycle();

        for (int i = 0; i < 6; i++) do_copy(tbl[i], $sformatf("vec%0d", i), 1'b0);

        // Write held off for 5 cycles: request must stay put, then exactly one write lands.
        rd_q.delete(); wr_q.delete();
        gnt_force = 1'b1; gnt_val = 1'b1; rv_delay = 0;
        src_addr = 32'h300; dst_addr = 32'h400; len = 16'd1; start = 1'b1;
        run_cycle();
        cyc = 0;
        while (!mem_wr_en && cyc < 20) begin run_cycle(); cyc++; end
        check("hold_reach_wr", mem_wr_en, 1);
        gnt_val = 1'b0;
        repeat (5) begin
            run_cycle();
            check("hold_mem_en", mem_en && mem_wr_en, 1);
            check("hold_addr", mem_addr, 32'h400);
            check("hold_wdata", mem_wdata, memval(32'h300));
        end
        check("hold_no_write_yet", wr_q.size(), 0);
        gnt_val = 1'b1;
        cyc = 0;
        while (!done && cyc < 20) begin run_cycle(); cyc++; end
        check("hold_done", done, 1);
        check("hold_one_write", wr_q.size(), 1);
        if (wr_q.size() > 0) check("hold_write", wr_q[0], {32'h400, memval(32'h300)});
        run_cycle();

        // Abort coinciding with the second write grant of a 4-word copy.
        rd_q.delete(); wr_q.delete();
        src_addr = 32'h700; dst_addr = 32'h900; len = 16'd4; start = 1'b1;
        run_cycle();
        cyc = 0;
        while (!(mem_wr_en && xfer_count == 16'd1) && cyc < 50) begin run_cycle(); cyc++; end
        check("abort_reach_wr2", mem_wr_en && xfer_count == 16'd1, 1);
        abort = 1'b1;
        run_cycle();
        check("abort_idle", busy, 0);
        check("abort_mem_en", mem_en, 0);
        check("abort_xfer_count", xfer_count, 1);
        dcount = done ? 1 : 0;
        repeat (4) begin run_cycle(); if (done) dcount++; end
        check("abort_no_done", dcount, 0);
        check("abort_writes", wr_q.size(), 1);

        // Abort while idle is ignored, even alongside a start.
        abort = 1'b1;
        run_cycle();
        check("idle_abort_busy", busy, 0);
        check("idle_abort_count", xfer_count, 1);
        src_addr = 32'h20; dst_addr = 32'h30; len = 16'd1; start = 1'b1; abort = 1'b1;
        run_cycle();
        check("start_with_abort_busy", busy, 1);
        cyc = 0;
        while (!done && cyc < 20) begin run_cycle(); cyc++; end
        check("start_with_abort_count", xfer_count, 1);
        run_cycle();

        // Reset while waiting for read data, with start held during reset.
        gnt_val = 1'b1; rv_delay = 6;
        src_addr = 32'h50; dst_addr = 32'h60; len = 16'd3; start = 1'b1;
        run_cycle();
        cyc = 0;
        while (!(busy && !mem_en) && cyc < 20) begin run_cycle(); cyc++; end
        check("rst_reach_rd_wait", busy && !mem_en, 1);
        rst = 1'b1; start = 1'b1;
        run_cycle();
        start = 1'b1;
        run_cycle();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_xfer_count", xfer_count, 0);
        check("rst_mem_en", mem_en | mem_wr_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        run_cycle();
        check("rst_start_ignored", busy, 0);
        rv_delay = 0;

        for (int k = 0; k < 25; k++) begin
            r.src     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4)) : $urandom;
            r.dst     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4)) : $urandom;
            r.n       = 16'($urandom_range(0, 7));
            r.pct     = $urandom_range(25, 100);
            r.rvd     = $urandom_range(0, 3);
            r.exp_cnt = r.n;
            r.lat     = (r.n == 0) ? 1 : -1;
            do_copy(r, $sformatf("rnd%0d", k), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
